// File: rtl/rs485_frame_serializer.sv
// ---------------------------------------------------------------------------
// rs485_frame_serializer
//
// Takes 16-bit words from the upstream TX FIFO and sends each one on the RS485
// line as two UART-framed bytes: start bit, 8 data bits LSB-first, an optional
// parity bit, and a stop bit. The transceiver driver enable is raised LEAD_BITS
// bit times before the first start bit and held TRAIL_BITS bit times after the
// last stop bit. The receiver echo (Rx) is compared with Tx at mid-bit during
// the framed bits, and any difference sets a sticky error flag.
//
// Ports
//   PCLK        in   clock, all logic on the rising edge
//   PRESET      in   synchronous reset, active-high
//   word_valid  in   FIFO has a word available
//   word_data   in   16-bit word, latched when accepted
//   word_ready  out  block can accept a word (IDLE and not in reset)
//   Rx          in   RS485 receiver output (line echo)
//   clr_err     in   clears echo_err
//   Tx          out  RS485 driver data, idles high (registered)
//   Tx_Enable   out  RS485 driver enable (registered)
//   Tx_complete out  one-cycle pulse on the first idle cycle after a word
//   busy        out  high in every state other than IDLE
//   echo_err    out  sticky echo mismatch flag
// ---------------------------------------------------------------------------
module rs485_frame_serializer #(
    parameter int CLKS_PER_BIT   = 16,
    parameter int LEAD_BITS      = 1,
    parameter int TRAIL_BITS     = 1,
    parameter int PARITY_EN      = 0,
    parameter int PARITY_ODD     = 0,
    parameter int MSB_BYTE_FIRST = 1
) (
    input  logic        PCLK,
    input  logic        PRESET,
    input  logic        word_valid,
    input  logic [15:0] word_data,
    output logic        word_ready,
    input  logic        Rx,
    input  logic        clr_err,
    output logic        Tx,
    output logic        Tx_Enable,
    output logic        Tx_complete,
    output logic        busy,
    output logic        echo_err
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LEAD   = 3'd1;
    localparam logic [2:0] S_START  = 3'd2;
    localparam logic [2:0] S_DATA   = 3'd3;
    localparam logic [2:0] S_PARITY = 3'd4;
    localparam logic [2:0] S_STOP   = 3'd5;
    localparam logic [2:0] S_TRAIL  = 3'd6;

    // Bit-time down-counter: holds CLKS_PER_BIT-1 .. 0.
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_RELOAD = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_HALF   = CW'(CLKS_PER_BIT / 2);

    // Guard-bit counter shared by the lead and trail phases.
    localparam int GMAX = (LEAD_BITS > TRAIL_BITS) ? LEAD_BITS : TRAIL_BITS;
    localparam int GW   = (GMAX > 1) ? $clog2(GMAX) : 1;

    logic [2:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [GW-1:0] guard_q, guard_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic          byte_sel_q, byte_sel_d;
    logic [15:0]   word_q, word_d;
    logic          tx_q, tx_d;
    logic          txen_q, txen_d;
    logic          done_q, done_d;
    logic          err_q, err_d;

    logic [7:0]    first_byte, second_byte, cur_byte;
    logic          parity_bit;
    logic          bit_end;
    logic          framed;
    logic          echo_sample;
    logic [2:0]    next_idx;

    assign first_byte  = (MSB_BYTE_FIRST != 0) ? word_q[15:8] : word_q[7:0];
    assign second_byte = (MSB_BYTE_FIRST != 0) ? word_q[7:0]  : word_q[15:8];
    assign cur_byte    = byte_sel_q ? second_byte : first_byte;
    assign parity_bit  = (PARITY_ODD != 0) ? ~^cur_byte : ^cur_byte;
    assign bit_end     = (cnt_q == '0);
    assign next_idx    = bit_idx_q + 3'd1;

    // Echo is checked only on bits that belong to a UART frame.
    assign framed      = (state_q == S_START) || (state_q == S_DATA) ||
                         (state_q == S_PARITY) || (state_q == S_STOP);
    assign echo_sample = framed && (cnt_q == CNT_HALF);

    assign word_ready  = (state_q == S_IDLE) && !PRESET;
    assign busy        = (state_q != S_IDLE);
    assign Tx          = tx_q;
    assign Tx_Enable   = txen_q;
    assign Tx_complete = done_q;
    assign echo_err    = err_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        guard_d    = guard_q;
        bit_idx_d  = bit_idx_q;
        byte_sel_d = byte_sel_q;
        word_d     = word_q;
        tx_d       = tx_q;
        txen_d     = txen_q;
        done_d     = 1'b0;
        err_d      = err_q;

        // Clear first so that a mismatch in the same cycle wins.
        if (clr_err) begin
            err_d = 1'b0;
        end
        if (echo_sample && (Rx != tx_q)) begin
            err_d = 1'b1;
        end

        if (state_q != S_IDLE) begin
            cnt_d = bit_end ? CNT_RELOAD : (cnt_q - CW'(1));
        end

        // Tx is loaded at the bit boundary with the level of the bit being
        // entered, so the output is a clean flop with no decode glitches.
        case (state_q)
            S_IDLE: begin
                if (word_valid && word_ready) begin
                    word_d     = word_data;
                    state_d    = S_LEAD;
                    cnt_d      = CNT_RELOAD;
                    guard_d    = GW'(LEAD_BITS - 1);
                    byte_sel_d = 1'b0;
                    txen_d     = 1'b1;
                    tx_d       = 1'b1;
                end
            end
            S_LEAD: begin
                if (bit_end) begin
                    if (guard_q == '0) begin
                        state_d = S_START;
                        tx_d    = 1'b0;
                    end else begin
                        guard_d = guard_q - GW'(1);
                    end
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_d   = S_DATA;
                    bit_idx_d = 3'd0;
                    tx_d      = cur_byte[0];
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    if (bit_idx_q == 3'd7) begin
                        if (PARITY_EN != 0) begin
                            state_d = S_PARITY;
                            tx_d    = parity_bit;
                        end else begin
                            state_d = S_STOP;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        bit_idx_d = next_idx;
                        tx_d      = cur_byte[next_idx];
                    end
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    state_d = S_STOP;
                    tx_d    = 1'b1;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    if (!byte_sel_q) begin
                        byte_sel_d = 1'b1;
                        state_d    = S_START;
                        tx_d       = 1'b0;
                    end else if (TRAIL_BITS == 0) begin
                        state_d = S_IDLE;
                        txen_d  = 1'b0;
                        done_d  = 1'b1;
                        tx_d    = 1'b1;
                    end else begin
                        state_d = S_TRAIL;
                        guard_d = GW'(TRAIL_BITS - 1);
                        tx_d    = 1'b1;
                    end
                end
            end
            S_TRAIL: begin
                if (bit_end) begin
                    if (guard_q == '0) begin
                        state_d = S_IDLE;
                        txen_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        guard_d = guard_q - GW'(1);
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                txen_d  = 1'b0;
                tx_d    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            guard_q    <= '0;
            bit_idx_q  <= 3'd0;
            byte_sel_q <= 1'b0;
            word_q     <= '0;
            tx_q       <= 1'b1;
            txen_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            guard_q    <= guard_d;
            bit_idx_q  <= bit_idx_d;
            byte_sel_q <= byte_sel_d;
            word_q     <= word_d;
            tx_q       <= tx_d;
            txen_q     <= txen_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

endmodule

// File: tb/tb_rs485_frame_serializer.sv
// ---------------------------------------------------------------------------
// tb_rs485_frame_serializer
//
// Directed bench for rs485_frame_serializer with CLKS_PER_BIT=4, LEAD=1,
// TRAIL=1. Instance 0 sends frames without parity, instance 1 with even
// parity. Each sent word is captured one bit per bit time (sampled one cycle
// into the bit) and compared with a hand-derived line pattern, where bit k of
// the pattern is the k-th bit time after acceptance (lead bit first).
// ---------------------------------------------------------------------------
module tb_rs485_frame_serializer;

    localparam int CPB = 4;

    logic        PCLK = 1'b0;
    logic        PRESET;
    logic [1:0]  valid_r;
    logic [1:0]  clr_r;
    logic [15:0] data_r [2];
    logic [1:0]  ready_w, tx_w, txen_w, done_w, busy_w, err_w;
    logic        rx0, rx1;
    logic        rx_force;

    int n_checks = 0;
    int n_errors = 0;

    always #5 PCLK = ~PCLK;

    // Instance 0's echo can be pulled low to provoke a mismatch.
    assign rx0 = rx_force ? 1'b0 : tx_w[0];
    assign rx1 = tx_w[1];

    rs485_frame_serializer #(
        .CLKS_PER_BIT(CPB), .LEAD_BITS(1), .TRAIL_BITS(1),
        .PARITY_EN(0), .PARITY_ODD(0), .MSB_BYTE_FIRST(1)
    ) u_dut (
        .PCLK(PCLK), .PRESET(PRESET),
        .word_valid(valid_r[0]), .word_data(data_r[0]), .word_ready(ready_w[0]),
        .Rx(rx0), .clr_err(clr_r[0]),
        .Tx(tx_w[0]), .Tx_Enable(txen_w[0]), .Tx_complete(done_w[0]),
        .busy(busy_w[0]), .echo_err(err_w[0])
    );

    rs485_frame_serializer #(
        .CLKS_PER_BIT(CPB), .LEAD_BITS(1), .TRAIL_BITS(1),
        .PARITY_EN(1), .PARITY_ODD(0), .MSB_BYTE_FIRST(1)
    ) u_dut_par (
        .PCLK(PCLK), .PRESET(PRESET),
        .word_valid(valid_r[1]), .word_data(data_r[1]), .word_ready(ready_w[1]),
        .Rx(rx1), .clr_err(clr_r[1]),
        .Tx(tx_w[1]), .Tx_Enable(txen_w[1]), .Tx_complete(done_w[1]),
        .busy(busy_w[1]), .echo_err(err_w[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    task automatic step();
        @(posedge PCLK);
        #1;
    endtask

    // Present a word and let it be accepted; returns in cycle 0 of LEAD.
    task automatic start_word(input int sel, input logic [15:0] w);
        valid_r[sel] = 1'b1;
        data_r[sel]  = w;
        step();
    endtask

    // Runs from cycle 0 of LEAD until Tx_Enable drops (bounded). Rx of
    // instance 0 is forced low for cycles f_from..f_to. With chg set,
    // word_data is scrambled every cycle to show it is ignored mid-frame.
    task automatic run_body(input int sel, input int f_from, input int f_to,
                            input bit chg, output logic [31:0] bits,
                            output int en, output int first_err, output int ready_hi);
        int cyc;
        bits      = '0;
        en        = 0;
        first_err = -1;
        ready_hi  = 0;
        cyc       = 0;
        while (txen_w[sel] === 1'b1 && cyc < 400) begin
            rx_force = (cyc >= f_from) && (cyc <= f_to);
            if ((cyc % CPB) == 1 && (cyc / CPB) < 32) begin
                bits[cyc / CPB] = tx_w[sel];
            end
            if (err_w[sel] === 1'b1 && first_err < 0) begin
                first_err = cyc;
            end
            if (ready_w[sel] === 1'b1) begin
                ready_hi++;
            end
            if (chg) begin
                data_r[sel] = 16'($urandom);
            end
            en++;
            step();
            cyc++;
        end
        rx_force = 1'b0;
        check("frame_ends", {31'b0, txen_w[sel]}, 32'd0);
    endtask

    logic [31:0] bits;
    int          en, first_err, ready_hi, pulses, en_hi;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        PRESET    = 1'b1;
        valid_r   = '0;
        clr_r     = '0;
        data_r[0] = '0;
        data_r[1] = '0;
        rx_force  = 1'b0;
        step();
        step();

        // Reset state (word_ready is held low while PRESET is asserted).
        check("rst_tx",    {31'b0, tx_w[0]},    32'd1);
        check("rst_txen",  {31'b0, txen_w[0]},  32'd0);
        check("rst_done",  {31'b0, done_w[0]},  32'd0);
        check("rst_busy",  {31'b0, busy_w[0]},  32'd0);
        check("rst_err",   {31'b0, err_w[0]},   32'd0);
        check("rst_ready", {31'b0, ready_w[0]}, 32'd0);
        PRESET = 1'b0;
        #1;
        check("idle_ready", {31'b0, ready_w[0]}, 32'd1);
        for (int i = 0; i < 10; i++) step();
        check("idle_hold", {30'b0, txen_w[0], tx_w[0]}, 32'h1);

        // 1: word 0xA53C, no parity.
        start_word(0, 16'hA53C);
        valid_r[0] = 1'b0;
        check("t1_lead", {29'b0, txen_w[0], busy_w[0], ready_w[0]}, 32'h6);
        run_body(0, -1, -1, 1'b0, bits, en, first_err, ready_hi);
        check("t1_bits",  bits & 32'h003F_FFFF, 32'h0033_C695);
        check("t1_en",    32'(en), 32'd88);
        check("t1_noerr", 32'(first_err), 32'hFFFF_FFFF);
        check("t1_done",  {30'b0, done_w[0], ready_w[0]}, 32'h3);
        step();
        check("t1_done_1cyc", {30'b0, done_w[0], busy_w[0]}, 32'h0);

        // 2: even parity, word 0x0700 (parity bits 1 then 0).
        start_word(1, 16'h0700);
        valid_r[1] = 1'b0;
        run_body(1, -1, -1, 1'b0, bits, en, first_err, ready_hi);
        check("t2_bits", bits & 32'h00FF_FFFF, 32'h00C0_0C1D);
        check("t2_par0", {31'b0, bits[10]}, 32'd1);
        check("t2_par1", {31'b0, bits[21]}, 32'd0);
        check("t2_en",   32'(en), 32'd96);
        check("t2_done", {31'b0, done_w[1]}, 32'd1);
        step();

        // 3: Rx forced low across byte0 data bit 3 (a '1' in 0x0F).
        start_word(0, 16'h0F0F);
        valid_r[0] = 1'b0;
        run_body(0, 20, 23, 1'b0, bits, en, first_err, ready_hi);
        check("t3_first_err", 32'(first_err), 32'd22);
        check("t3_en",        32'(en), 32'd88);
        check("t3_err_held",  {31'b0, err_w[0]}, 32'd1);
        check("t3_done",      {31'b0, done_w[0]}, 32'd1);
        clr_r[0] = 1'b1;
        step();
        clr_r[0] = 1'b0;
        check("t3_clr", {31'b0, err_w[0]}, 32'd0);

        // 6: word_valid high while busy, word_data scrambled mid-frame.
        start_word(0, 16'h5AC3);
        run_body(0, -1, -1, 1'b1, bits, en, first_err, ready_hi);
        valid_r[0] = 1'b0;
        check("t6_ready_low", 32'(ready_hi), 32'd0);
        check("t6_bits",      bits & 32'h003F_FFFF, 32'h003C_3569);
        check("t6_done",      {31'b0, done_w[0]}, 32'd1);
        step();
        check("t6_no_accept", {31'b0, txen_w[0]}, 32'd0);

        // 5: back-to-back words with word_valid held high.
        start_word(0, 16'h1111);
        data_r[0] = 16'h2222;
        run_body(0, -1, -1, 1'b0, bits, en, first_err, ready_hi);
        check("t5_bits_w0", bits & 32'h003F_FFFF, 32'h0031_1445);
        check("t5_en_w0",   32'(en), 32'd88);
        check("t5_done_rdy", {30'b0, done_w[0], ready_w[0]}, 32'h3);
        step();
        check("t5_gap_1cyc", {30'b0, txen_w[0], busy_w[0]}, 32'h3);
        valid_r[0] = 1'b0;
        run_body(0, -1, -1, 1'b0, bits, en, first_err, ready_hi);
        check("t5_bits_w1", bits & 32'h003F_FFFF, 32'h0032_2489);
        check("t5_done_w1", {31'b0, done_w[0]}, 32'd1);
        step();

        // 4: reset during byte1 DATA after an echo error was flagged.
        start_word(0, 16'hA53C);
        valid_r[0] = 1'b0;
        for (int c = 0; c < 53; c++) begin
            rx_force = (c >= 8) && (c <= 11);
            step();
        end
        rx_force = 1'b0;
        check("t4_pre_state", {30'b0, err_w[0], busy_w[0]}, 32'h3);
        PRESET = 1'b1;
        step();
        check("t4_rst_lines", {29'b0, tx_w[0], txen_w[0], busy_w[0]}, 32'h4);
        check("t4_rst_err",   {31'b0, err_w[0]}, 32'd0);
        PRESET = 1'b0;
        #1;
        check("t4_ready", {31'b0, ready_w[0]}, 32'd1);
        pulses = 0;
        en_hi  = 0;
        for (int c = 0; c < 30; c++) begin
            if (done_w[0] === 1'b1) pulses++;
            if (txen_w[0] === 1'b1) en_hi++;
            step();
        end
        check("t4_no_done", 32'(pulses), 32'd0);
        check("t4_idle_en", 32'(en_hi),  32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
